// File: rtl/wrr_read_scheduler.sv
// QoS read sequencer: steers ingress words into the per-VC FIFOs and drains them into the
// output FIFO by weighted round robin, each VC spending up to its weight in reads per turn.
module wrr_read_scheduler #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int MAX_WEIGHT     = 64
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        enb,
  input  logic                                        iniciar,
  input  logic                                        data_valid,
  input  logic [((QUEUE_QUANTITY>1)?$clog2(QUEUE_QUANTITY):1)-1:0] vc_id,
  input  logic [QUEUE_QUANTITY*$clog2(MAX_WEIGHT)-1:0] pesos,
  input  logic [QUEUE_QUANTITY-1:0]                   buf_full,
  input  logic [QUEUE_QUANTITY-1:0]                   buf_empty,
  input  logic                                        out_almost_full,
  output logic [QUEUE_QUANTITY-1:0]                   wr_en,
  output logic [QUEUE_QUANTITY-1:0]                   rd_en,
  output logic                                        out_wr_en,
  output logic [((QUEUE_QUANTITY>1)?$clog2(QUEUE_QUANTITY):1)-1:0] selector,
  output logic [QUEUE_QUANTITY-1:0]                   drop_err,
  output logic                                        idle
);
  localparam int Q  = QUEUE_QUANTITY;
  localparam int CW = $clog2(MAX_WEIGHT);
  localparam int IW = (Q > 1) ? $clog2(Q) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_NEXT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, nxt_ptr;
  logic [CW-1:0]   credit_q, credit_d;
  logic [Q-1:0]    rd_en_d, rd_en_p0;
  logic            out_wr_en_p1;
  logic [IW-1:0]   selector_p1;
  logic [Q-1:0]    drop_d, drop_err_q;
  logic            eligible;

  function automatic logic [CW-1:0] weight_of(input logic [IW-1:0] idx);
    return pesos[idx*CW +: CW];
  endfunction

  // Ingress steering: combinational write enable, registered drop pulse
  always_comb begin
    wr_en  = '0;
    drop_d = '0;
    if (enb && data_valid && (state_q != S_IDLE)) begin
      if (buf_full[vc_id]) drop_d[vc_id] = 1'b1;
      else                 wr_en[vc_id]  = 1'b1;
    end
  end

  assign nxt_ptr  = ptr_q + IW'(1);
  assign eligible = !buf_empty[ptr_q] && (credit_q != '0);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    rd_en_d  = '0;
    case (state_q)
      S_IDLE:  if (iniciar) state_d = S_LOAD;
      S_LOAD: begin
        ptr_d    = '0;
        credit_d = weight_of('0);
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        if (eligible && !out_almost_full) begin
          rd_en_d  = Q'(1) << ptr_q;
          credit_d = credit_q - CW'(1);
          state_d  = S_WAIT;
        end else if (!eligible) begin
          state_d  = S_NEXT;
        end
      end
      // Empty flag of the VC just read is only trustworthy one cycle later
      S_WAIT:  state_d = (credit_q != '0) ? S_ISSUE : S_NEXT;
      S_NEXT: begin
        ptr_d    = nxt_ptr;
        credit_d = weight_of(nxt_ptr);
        state_d  = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
    if (iniciar && (state_q != S_IDLE)) begin
      state_d  = S_LOAD;
      ptr_d    = ptr_q;
      credit_d = credit_q;
      rd_en_d  = '0;
    end
  end

  // Stage p0: read issue; stage p1: output FIFO write one cycle behind the read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      credit_q     <= '0;
      rd_en_p0     <= '0;
      out_wr_en_p1 <= 1'b0;
      selector_p1  <= '0;
    end else if (enb) begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      credit_q     <= credit_d;
      rd_en_p0     <= rd_en_d;
      out_wr_en_p1 <= |rd_en_p0;
      if (|rd_en_p0) selector_p1 <= ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_err_q <= '0;
    else      drop_err_q <= drop_d;
  end

  // Frozen pipeline contents are held but not presented while enb is low
  assign rd_en     = enb ? rd_en_p0 : '0;
  assign out_wr_en = enb & out_wr_en_p1;
  assign selector  = selector_p1;
  assign drop_err  = drop_err_q;
  assign idle      = ((state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_NEXT)) &&
                     (&buf_empty) && !(|rd_en_p0) && !out_wr_en_p1;

endmodule

// File: tb/tb_wrr_read_scheduler.sv
// Bench for wrr_read_scheduler: FIFO occupancy model around the DUT, expected read order
// computed per round from weights and occupancy, plus directed corner cases.
module tb_wrr_read_scheduler;
  localparam int Q     = 4;
  localparam int CW    = 6;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst, enb, iniciar, data_valid;
  logic [1:0] vc_id;
  logic [Q*CW-1:0] pesos;
  logic [Q-1:0] buf_full, buf_empty;
  logic out_almost_full;
  logic [Q-1:0] wr_en, rd_en, drop_err;
  logic out_wr_en;
  logic [1:0] selector;
  logic idle;

  logic afull_dir, afull_rnd, bp_rand;
  int cnt[Q];
  int ld_val[Q];
  logic ld_en;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [1:0] rdq[$];
  int rdcyc[$];
  logic [1:0] exp_vc[$];
  int exp_turn[$];
  logic exp_idle;
  int base_q, base_c;
  logic [Q-1:0] prev_rd = '0;
  logic prev_enb = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign out_almost_full = afull_dir | afull_rnd;

  // VC FIFO occupancy model driven by the DUT enables
  always @(posedge clk) begin
    for (int i = 0; i < Q; i++) begin
      if (ld_en) cnt[i] <= ld_val[i];
      else cnt[i] <= cnt[i] + ((wr_en[i] && cnt[i] < DEPTH) ? 1 : 0)
                            - ((rd_en[i] && cnt[i] > 0) ? 1 : 0);
    end
  end

  always_comb begin
    buf_empty = '0;
    buf_full  = '0;
    for (int i = 0; i < Q; i++) begin
      buf_empty[i] = (cnt[i] == 0);
      buf_full[i]  = (cnt[i] >= DEPTH);
    end
  end

  wrr_read_scheduler dut (
    .clk(clk), .rst(rst), .enb(enb), .iniciar(iniciar), .data_valid(data_valid),
    .vc_id(vc_id), .pesos(pesos), .buf_full(buf_full), .buf_empty(buf_empty),
    .out_almost_full(out_almost_full), .wr_en(wr_en), .rd_en(rd_en),
    .out_wr_en(out_wr_en), .selector(selector), .drop_err(drop_err), .idle(idle)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [Q-1:0] oh);
    for (int i = 0; i < Q; i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  // Read monitor: records issued reads and checks the output write follows one cycle later
  always @(negedge clk) begin
    if (rst) begin
      if (rd_en != '0) rdcyc.push_back(cyc);
      if (out_wr_en) rdq.push_back(selector);
      if (prev_enb && enb) begin
        check("owe_follows_rd", 32'(out_wr_en), 32'(|prev_rd));
        if (out_wr_en) check("sel_vs_rd", 32'(selector), 32'(idx_of(prev_rd)));
      end
    end
    prev_rd  <= rd_en;
    prev_enb <= enb & rst;
  end

  initial begin
    afull_rnd = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      afull_rnd = bp_rand && ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input int a, input int b, input int c, input int d);
    ld_val[0] = a; ld_val[1] = b; ld_val[2] = c; ld_val[3] = d;
    ld_en = 1'b1;
    step();
    ld_en = 1'b0;
  endtask

  // Expected order: visit VCs 0..Q-1 repeatedly, each turn takes min(weight, occupancy)
  function automatic void build_exp(input logic [Q*CW-1:0] w, input int c[Q]);
    int cc[Q];
    int turn;
    bit prog;
    int n;
    exp_vc.delete();
    exp_turn.delete();
    for (int v = 0; v < Q; v++) cc[v] = c[v];
    turn = 0;
    prog = 1'b1;
    while (prog) begin
      prog = 1'b0;
      for (int v = 0; v < Q; v++) begin
        n = int'(w[v*CW +: CW]);
        if (cc[v] < n) n = cc[v];
        for (int k = 0; k < n; k++) begin
          exp_vc.push_back(2'(v));
          exp_turn.push_back(turn);
        end
        cc[v] -= n;
        if (n > 0) prog = 1'b1;
        turn++;
      end
    end
    exp_idle = 1'b1;
    for (int v = 0; v < Q; v++) if (cc[v] != 0) exp_idle = 1'b0;
  endfunction

  task automatic start(input logic [Q*CW-1:0] w);
    pesos   = w;
    base_q  = rdq.size();
    base_c  = rdcyc.size();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
  endtask

  task automatic run_check(input string nm, input bit spacing, input int budget);
    int got_n;
    for (int i = 0; i < budget && (rdq.size() - base_q) < exp_vc.size(); i++) step();
    repeat (8) step();
    got_n = rdq.size() - base_q;
    check({nm, "_reads"}, 32'(got_n), 32'(exp_vc.size()));
    for (int k = 0; k < exp_vc.size() && k < got_n; k++)
      check({nm, "_vc"}, 32'(rdq[base_q+k]), 32'(exp_vc[k]));
    if (spacing)
      for (int k = 1; k < exp_vc.size() && base_c + k < rdcyc.size(); k++)
        if (exp_turn[k] == exp_turn[k-1])
          check({nm, "_gap"}, 32'(rdcyc[base_c+k] - rdcyc[base_c+k-1]), 32'd2);
    check({nm, "_idle"}, 32'(idle), 32'(exp_idle));
  endtask

  initial begin
    logic [Q*CW-1:0] w;
    int c[Q];
    rst = 1'b0; enb = 1'b1; iniciar = 1'b0; data_valid = 1'b0; vc_id = 2'd0;
    pesos = '0; afull_dir = 1'b0; bp_rand = 1'b0; ld_en = 1'b0;
    for (int i = 0; i < Q; i++) ld_val[i] = 0;

    // Reset values and IDLE behaviour
    repeat (3) step();
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_out_wr_en", 32'(out_wr_en), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
    check("rst_selector", 32'(selector), 32'd0);
    check("rst_idle", 32'(idle), 32'd0);
    rst = 1'b1;
    step();
    data_valid = 1'b1; vc_id = 2'd1;
    #1 check("idle_wr_ignored", 32'(wr_en), 32'd0);
    step();
    check("idle_no_drop", 32'(drop_err), 32'd0);
    check("idle_flag_in_idle", 32'(idle), 32'd0);
    data_valid = 1'b0;

    // WRR with weights {1,1,2,3}
    preload(8, 8, 8, 8);
    w = {6'd1, 6'd1, 6'd2, 6'd3};
    build_exp(w, ld_val);
    start(w);
    run_check("wrr", 1'b1, 600);

    // Skip of zero weight and empty VCs
    preload(2, 0, 0, 2);
    w = {6'd4, 6'd4, 6'd0, 6'd4};
    build_exp(w, ld_val);
    start(w);
    run_check("skip", 1'b1, 300);

    // Backpressure held for 10 cycles mid-burst
    preload(6, 6, 0, 0);
    w = {6'd0, 6'd0, 6'd3, 6'd4};
    build_exp(w, ld_val);
    start(w);
    for (int i = 0; i < 200 && (rdq.size() - base_q) < 2; i++) step();
    afull_dir = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_no_rd", 32'(rd_en), 32'd0);
    end
    afull_dir = 1'b0;
    run_check("bp", 1'b0, 400);

    // Overflow on a full VC, normal write to another
    preload(0, 0, 8, 0);
    w = {6'd0, 6'd1, 6'd1, 6'd1};
    c[0] = 0; c[1] = 0; c[2] = 8; c[3] = 1;
    build_exp(w, c);
    start(w);
    data_valid = 1'b1; vc_id = 2'd2;
    #1 check("ovf_wr_en", 32'(wr_en), 32'd0);
    step();
    check("ovf_drop", 32'(drop_err), 32'b0100);
    vc_id = 2'd3;
    #1 check("wr_en_vc3", 32'(wr_en), 32'b1000);
    step();
    check("ovf_drop_pulse", 32'(drop_err), 32'd0);
    data_valid = 1'b0;
    step();
    check("no_drop_after", 32'(drop_err), 32'd0);
    run_check("ovf", 1'b1, 600);

    // Restart while serving VC2
    preload(8, 8, 8, 8);
    w = {6'd2, 6'd2, 6'd2, 6'd2};
    start(w);
    for (int i = 0; i < 300 && rd_en != 4'b0100; i++) step();
    check("restart_at_vc2", 32'(rd_en), 32'b0100);
    pesos   = {6'd2, 6'd0, 6'd3, 6'd1};
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    check("restart_inflight", 32'(rdq[rdq.size()-1]), 32'd2);
    for (int i = 0; i < Q; i++) c[i] = cnt[i];
    base_q = rdq.size();
    base_c = rdcyc.size();
    build_exp(pesos, c);
    run_check("restart", 1'b1, 800);

    // enb low freezes everything
    preload(5, 5, 5, 5);
    w = {6'd2, 6'd2, 6'd2, 6'd2};
    build_exp(w, ld_val);
    start(w);
    for (int i = 0; i < 200 && (rdq.size() - base_q) < 3; i++) step();
    enb = 1'b0; data_valid = 1'b1; vc_id = 2'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("enb_rd_en", 32'(rd_en), 32'd0);
      check("enb_out_wr_en", 32'(out_wr_en), 32'd0);
      check("enb_wr_en", 32'(wr_en), 32'd0);
    end
    enb = 1'b1; data_valid = 1'b0;
    run_check("enb", 1'b0, 600);

    // Randomized weights, occupancy and backpressure
    for (int t = 0; t < 12; t++) begin
      bp_rand = 1'(($urandom_range(0, 1)));
      for (int i = 0; i < Q; i++) ld_val[i] = $urandom_range(0, 6);
      ld_en = 1'b1;
      step();
      ld_en = 1'b0;
      for (int i = 0; i < Q; i++) w[i*CW +: CW] = 6'($urandom_range(0, 4));
      build_exp(w, ld_val);
      start(w);
      run_check("rand", !bp_rand, 800);
      bp_rand = 1'b0;
    end

    // Asynchronous reset during traffic
    preload(8, 8, 8, 8);
    w = {6'd2, 6'd2, 6'd2, 6'd2};
    start(w);
    for (int i = 0; i < 200 && rd_en == '0; i++) step();
    check("pre_reset_rd", 32'(rd_en != '0), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_rd_en", 32'(rd_en), 32'd0);
    check("mid_rst_out_wr_en", 32'(out_wr_en), 32'd0);
    check("mid_rst_drop", 32'(drop_err), 32'd0);
    check("mid_rst_idle", 32'(idle), 32'd0);
    step();
    check("rst_cancel_owe", 32'(out_wr_en), 32'd0);
    rst = 1'b1;
    data_valid = 1'b1; vc_id = 2'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_rd_en", 32'(rd_en), 32'd0);
      check("post_rst_wr_en", 32'(wr_en), 32'd0);
      check("post_rst_idle", 32'(idle), 32'd0);
    end
    data_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
